// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner with per-round debounce, one-cycle KEY_VALID strobe and held level.
// Optional auto-repeat of the held key is compiled in when KEY_REPEAT_EN is defined.
module keypad_matrix_scanner #(
  parameter int unsigned COL_DWELL      = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 20,
  parameter int unsigned REPEAT_DELAY   = 500,
  parameter int unsigned REPEAT_RATE    = 100
) (
  input  logic       CLK100MHZ,
  input  logic       RST_N,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] KEY,
  output logic       KEY_VALID,
  output logic       KEY_HELD
);

  localparam int unsigned DW = (COL_DWELL > 1) ? $clog2(COL_DWELL) : 1;
  localparam int unsigned SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(COL_DWELL - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  if (COL_DWELL < 4 || DEBOUNCE_SCANS < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("keypad_matrix_scanner: parameter below minimum");
  end

  typedef enum logic {
    S_IDLE,
    S_PRESSED
  } state_t;

  state_t          r_state, w_state_next;
  logic [3:0]      r_row_meta, r_row_sync;
  logic [DW-1:0]   r_dwell;
  logic [1:0]      r_col_idx;
  logic            r_part_found;
  logic [3:0]      r_part_code;
  logic            r_prev_none;
  logic [3:0]      r_prev_code;
  logic [SW-1:0]   r_stable, w_stable_next;
  logic [3:0]      r_key, w_key_next;
  logic            r_valid, w_valid_next;

  logic            w_last;
  logic            w_round_end;
  logic            w_col_hit;
  logic [1:0]      w_col_row;
  logic            w_res_none;
  logic [3:0]      w_res_code;
  logic            w_same;
  logic            w_stable_done;

  assign w_last      = (r_dwell == DWELL_LAST);
  assign w_round_end = w_last && (r_col_idx == 2'd3);

  // Lowest active row in the currently driven column.
  always_comb begin
    w_col_hit = 1'b0;
    w_col_row = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!r_row_sync[i] && !w_col_hit) begin
        w_col_hit = 1'b1;
        w_col_row = 2'(i);
      end
    end
  end

  always_comb begin
    w_res_none = 1'b1;
    w_res_code = '0;
    if (r_part_found) begin
      w_res_none = 1'b0;
      w_res_code = r_part_code;
    end else if (w_col_hit) begin
      w_res_none = 1'b0;
      w_res_code = {w_col_row, r_col_idx};
    end
  end

  assign w_same = ({w_res_none, w_res_code} == {r_prev_none, r_prev_code});

  always_comb begin
    w_stable_next = SW'(1);
    if (w_same) begin
      w_stable_next = (r_stable == STABLE_MAX) ? STABLE_MAX : r_stable + 1'b1;
    end
  end

  assign w_stable_done = (w_stable_next == STABLE_MAX);

`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] r_rep_cnt, w_rep_cnt_next;
  logic          r_rep_first, w_rep_first_next;
`endif

  always_comb begin
    w_state_next = r_state;
    w_key_next   = r_key;
    w_valid_next = 1'b0;
    if (w_round_end && w_stable_done) begin
      case (r_state)
        S_IDLE: begin
          if (!w_res_none) begin
            w_key_next   = w_res_code;
            w_valid_next = 1'b1;
            w_state_next = S_PRESSED;
          end
        end
        S_PRESSED: begin
          if (w_res_none) begin
            w_state_next = S_IDLE;
          end else if (w_res_code != r_key) begin
            w_key_next   = w_res_code;
            w_valid_next = 1'b1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
`ifdef KEY_REPEAT_EN
    w_rep_cnt_next   = r_rep_cnt;
    w_rep_first_next = r_rep_first;
    if (w_round_end) begin
      if (r_state != S_PRESSED || w_state_next != S_PRESSED || w_key_next != r_key) begin
        w_rep_cnt_next   = '0;
        w_rep_first_next = 1'b1;
      end else if (!w_res_none && w_res_code == r_key) begin
        // First repeat waits REPEAT_DELAY rounds, later ones REPEAT_RATE.
        if (r_rep_cnt == (r_rep_first ? REP_FIRST : REP_NEXT)) begin
          w_valid_next     = 1'b1;
          w_rep_cnt_next   = '0;
          w_rep_first_next = 1'b0;
        end else begin
          w_rep_cnt_next = r_rep_cnt + 1'b1;
        end
      end
    end
`endif
  end

  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_row_meta   <= '0;
      r_row_sync   <= '0;
      r_dwell      <= '0;
      r_col_idx    <= '0;
      r_part_found <= 1'b0;
      r_part_code  <= '0;
      r_prev_none  <= 1'b0;
      r_prev_code  <= '0;
      r_stable     <= '0;
      r_key        <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_row_meta <= ROW;
      r_row_sync <= r_row_meta;
      r_key      <= w_key_next;
      r_valid    <= w_valid_next;
      if (w_last) begin
        r_dwell   <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        if (r_col_idx == 2'd3) begin
          r_part_found <= 1'b0;
          r_part_code  <= '0;
          r_prev_none  <= w_res_none;
          r_prev_code  <= w_res_code;
          r_stable     <= w_stable_next;
        end else if (!r_part_found && w_col_hit) begin
          r_part_found <= 1'b1;
          r_part_code  <= {w_col_row, r_col_idx};
        end
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else begin
      r_rep_cnt   <= w_rep_cnt_next;
      r_rep_first <= w_rep_first_next;
    end
  end
`endif

  assign COL       = ~(4'b0001 << r_col_idx);
  assign KEY       = r_key;
  assign KEY_VALID = r_valid;
  assign KEY_HELD  = (r_state == S_PRESSED);

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural keypad; COL_DWELL=4, DEBOUNCE_SCANS=3.
// Rounds end on cycles 16, 32, 48, ... counted from reset release.
module tb_keypad_matrix_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;
  int          cyc;
  int          valid_cnt;
  int          vbase;
  int          checks;
  int          errors;

  keypad_matrix_scanner #(
    .COL_DWELL(4),
    .DEBOUNCE_SCANS(3),
    .REPEAT_DELAY(5),
    .REPEAT_RATE(2)
  ) dut (
    .CLK100MHZ(clk),
    .RST_N(rst_n),
    .ROW(row),
    .COL(col),
    .KEY(key),
    .KEY_VALID(key_valid),
    .KEY_HELD(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key at (r,c) is bit {r,c}; it pulls row r low while column c is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && key_valid) valid_cnt <= valid_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        checks++;
        errors++;
        $display("FAIL timeout: got cyc %0d expected %0d", cyc, n);
        return;
      end
    end
  endtask

  task automatic do_reset(input logic [15:0] k);
    keys  = k;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vbase = valid_cnt;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    valid_cnt = 0;
    keys      = '0;
    rst_n     = 1'b0;

    // Idle scan: reset values and column rotation.
    do_reset(16'h0000);
    check_eq("rst_col", col, 4'b1110);
    check_eq("rst_key", key, 4'h0);
    check_eq("rst_valid", key_valid, 1'b0);
    check_eq("rst_held", key_held, 1'b0);
    wait_cyc(4);  check_eq("col_step1", col, 4'b1101);
    wait_cyc(8);  check_eq("col_step2", col, 4'b1011);
    wait_cyc(12); check_eq("col_step3", col, 4'b0111);
    wait_cyc(16); check_eq("col_wrap", col, 4'b1110);
    wait_cyc(64);
    check_eq("idle_no_valid", valid_cnt - vbase, 0);
    check_eq("idle_held", key_held, 1'b0);

    // Single press (row1,col2) then release.
    do_reset(16'h0040);
    wait_cyc(47);
    check_eq("press_pre_valid", key_valid, 1'b0);
    check_eq("press_pre_held", key_held, 1'b0);
    wait_cyc(48);
    check_eq("press_valid", key_valid, 1'b1);
    check_eq("press_key", key, 4'h6);
    check_eq("press_held", key_held, 1'b1);
    wait_cyc(49);
    check_eq("press_pulse_end", key_valid, 1'b0);
    keys = 16'h0000;
    wait_cyc(95);
    check_eq("rel_still_held", key_held, 1'b1);
    wait_cyc(96);
    check_eq("rel_held", key_held, 1'b0);
    check_eq("rel_key_kept", key, 4'h6);
    check_eq("rel_one_valid", valid_cnt - vbase, 1);

    // Bounce: key present on alternate rounds for 6 rounds, then steady.
    do_reset(16'h0040);
    for (int i = 1; i <= 6; i++) begin
      wait_cyc(16 * i);
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
    end
    wait_cyc(143);
    check_eq("bounce_no_early", valid_cnt - vbase, 0);
    check_eq("bounce_no_held", key_held, 1'b0);
    wait_cyc(144);
    check_eq("bounce_valid", key_valid, 1'b1);
    check_eq("bounce_key", key, 4'h6);

    // Two keys: lowest column wins, then the remaining key is accepted.
    do_reset(16'h0108);
    wait_cyc(48);
    check_eq("multi_valid", key_valid, 1'b1);
    check_eq("multi_key", key, 4'h8);
    keys = 16'h0008;
    wait_cyc(95);
    check_eq("multi_key_hold", key, 4'h8);
    wait_cyc(96);
    check_eq("second_valid", key_valid, 1'b1);
    check_eq("second_key", key, 4'h3);
    check_eq("second_held", key_held, 1'b1);
    check_eq("second_count", valid_cnt - vbase, 1);

    // Reset during the second stable round of a press.
    do_reset(16'h0040);
    wait_cyc(24);
    check_eq("mid_col_before", col, 4'b1011);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_col", col, 4'b1110);
    check_eq("mid_rst_key", key, 4'h0);
    check_eq("mid_rst_valid", key_valid, 1'b0);
    check_eq("mid_rst_held", key_held, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    vbase = valid_cnt;
    wait_cyc(47);
    check_eq("mid_no_early", valid_cnt - vbase, 0);
    wait_cyc(48);
    check_eq("mid_valid", key_valid, 1'b1);
    check_eq("mid_key", key, 4'h6);

    // Long hold: auto-repeat when enabled, otherwise a single strobe.
    do_reset(16'h0040);
    wait_cyc(48);
    check_eq("hold_accept", key_valid, 1'b1);
`ifdef KEY_REPEAT_EN
    wait_cyc(127); check_eq("rep_pre1", key_valid, 1'b0);
    wait_cyc(128); check_eq("rep_5", key_valid, 1'b1);
    wait_cyc(160); check_eq("rep_7", key_valid, 1'b1);
    wait_cyc(192); check_eq("rep_9", key_valid, 1'b1);
    wait_cyc(224); check_eq("rep_11", key_valid, 1'b1);
    check_eq("rep_key", key, 4'h6);
    wait_cyc(240);
    check_eq("rep_count", valid_cnt - vbase, 5);
`else
    wait_cyc(240);
    check_eq("hold_single", valid_cnt - vbase, 1);
    check_eq("hold_held", key_held, 1'b1);
`endif
    keys = 16'h0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
